lab_digitize_sched: RTL and testbench

//  Schedules LAB digitization of the held storage buffers. TURF HOLD events mark

---
 rtl/lab_digitize_sched_pkg.sv | 18 +
 rtl/lab_digitize_sched_arb.sv | 32 +++
 rtl/lab_digitize_sched.sv | 139 +++++++++++++
 tb/tb_lab_digitize_sched.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lab_digitize_sched_pkg.sv
// Shared types for the LAB digitize scheduler: per-buffer and sequencer state encodings.
package lab_digitize_sched_pkg;

   localparam int unsigned NBUF_DEF = 4;

   typedef enum logic [1:0] {
      BUF_FREE       = 2'd0,
      BUF_PENDING    = 2'd1,
      BUF_DIGITIZING = 2'd2,
      BUF_READY      = 2'd3
   } buf_state_e;

   typedef enum logic {
      SEQ_IDLE = 1'b0,
      SEQ_WAIT = 1'b1
   } seq_state_e;

endpackage

// File: rtl/lab_digitize_sched_arb.sv
// Combinational round-robin arbiter: picks the first request strictly after ptr_i, cyclically.
module lab_digitize_sched_arb #(
   parameter int unsigned NBUF = 4,
   localparam int unsigned IW  = (NBUF > 1) ? $clog2(NBUF) : 1
) (
   input  logic [NBUF-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [NBUF-1:0] gnt_o,
   output logic [IW-1:0]   idx_o,
   output logic            valid_o
);

   logic [IW-1:0] cand;

   // Walk offsets from farthest to nearest so the nearest request wins.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = '0;
      for (int k = int'(NBUF); k >= 1; k--) begin
         cand = IW'((int'(ptr_i) + k) % int'(NBUF));
         if (req_i[cand]) begin
            gnt_o       = '0;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
            valid_o     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lab_digitize_sched.sv
// Schedules LAB digitization of held storage buffers: HOLD edges queue buffers, one digitize at a time.
module lab_digitize_sched
   import lab_digitize_sched_pkg::*;
#(
   parameter int unsigned NBUF    = NBUF_DEF,
   parameter int unsigned TIMEOUT = 4096,
   parameter int unsigned CNTW    = 16,
   localparam int unsigned IW     = (NBUF > 1) ? $clog2(NBUF) : 1
) (
   input  logic            clk_i,
   input  logic            nrst_i,
   input  logic            enable_i,
   input  logic [NBUF-1:0] hold_i,
   input  logic            done_i,
   input  logic [NBUF-1:0] clear_i,
   output logic [NBUF-1:0] digitize_o,
   output logic [NBUF-1:0] ready_o,
   output logic [IW-1:0]   cur_buf_o,
   output logic            busy_o,
   output logic            timeout_o,
   output logic [CNTW-1:0] drop_cnt_o
);

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned SW = CNTW + IW + 1;
   localparam logic [CNTW-1:0] CNT_MAX = '1;

   buf_state_e      state_q [NBUF];
   buf_state_e      state_d [NBUF];
   buf_state_e      eff;
   seq_state_e      seq_q;
   logic [NBUF-1:0] hold_q, digitize_q, ready_q;
   logic [NBUF-1:0] edge_c, pend_c, free_c, ready_c, arb_gnt;
   logic [IW-1:0]   ptr_q, cur_q, arb_idx;
   logic [TW-1:0]   timer_q;
   logic [CNTW-1:0] drop_q, drop_d;
   logic [SW-1:0]   drop_add, drop_sum;
   logic            busy_q, timeout_q, arb_valid;
   logic            issue_c, fin_done_c, fin_to_c;

   assign edge_c     = hold_i & ~hold_q;
   assign issue_c    = (seq_q == SEQ_IDLE) && enable_i && arb_valid;
   assign fin_done_c = (seq_q == SEQ_WAIT) && done_i;
   assign fin_to_c   = (seq_q == SEQ_WAIT) && !done_i && (timer_q == TW'(TIMEOUT - 1));

   always_comb begin
      for (int i = 0; i < int'(NBUF); i++) begin
         pend_c[i] = (state_q[i] == BUF_PENDING);
         free_c[i] = (state_q[i] == BUF_FREE);
      end
   end

   lab_digitize_sched_arb #(.NBUF(NBUF)) u_arb (
      .req_i   (pend_c),
      .ptr_i   (ptr_q),
      .gnt_o   (arb_gnt),
      .idx_o   (arb_idx),
      .valid_o (arb_valid)
   );

   // Per-buffer next state: host clear first, then HOLD edge, then sequencer transitions.
   always_comb begin
      state_d  = state_q;
      drop_add = '0;
      eff      = BUF_FREE;
      ready_c  = '0;
      for (int i = 0; i < int'(NBUF); i++) begin
         eff = state_q[i];
         if (eff == BUF_READY && clear_i[i]) eff = BUF_FREE;
         state_d[i] = eff;
         if (edge_c[i]) begin
            if (eff == BUF_FREE) state_d[i] = BUF_PENDING;
            else                 drop_add   = drop_add + SW'(1);
         end
         if (issue_c && arb_gnt[i])                  state_d[i] = BUF_DIGITIZING;
         if (fin_done_c && cur_q == IW'(i))          state_d[i] = BUF_READY;
         if (fin_to_c && cur_q == IW'(i))            state_d[i] = BUF_FREE;
         ready_c[i] = (state_d[i] == BUF_READY);
      end
      drop_sum = SW'(drop_q) + drop_add;
      drop_d   = (drop_sum > SW'(CNT_MAX)) ? CNT_MAX : CNTW'(drop_sum);
   end

   // Sequencer, timer and registered outputs.
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         for (int i = 0; i < int'(NBUF); i++) state_q[i] <= BUF_FREE;
         seq_q      <= SEQ_IDLE;
         hold_q     <= '0;
         ptr_q      <= IW'(NBUF - 1);
         cur_q      <= '0;
         digitize_q <= '0;
         ready_q    <= '0;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
         drop_q     <= '0;
         timer_q    <= '0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_i;
         ready_q   <= ready_c;
         busy_q    <= ~|free_c;
         drop_q    <= drop_d;
         timeout_q <= 1'b0;
         case (seq_q)
            SEQ_IDLE: begin
               timer_q <= '0;
               if (issue_c) begin
                  cur_q      <= arb_idx;
                  ptr_q      <= arb_idx;
                  digitize_q <= arb_gnt;
                  seq_q      <= SEQ_WAIT;
               end
            end
            SEQ_WAIT: begin
               if (fin_done_c) begin
                  digitize_q <= '0;
                  seq_q      <= SEQ_IDLE;
               end else if (fin_to_c) begin
                  digitize_q <= '0;
                  timeout_q  <= 1'b1;
                  seq_q      <= SEQ_IDLE;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            default: seq_q <= SEQ_IDLE;
         endcase
      end
   end

   assign digitize_o = digitize_q;
   assign ready_o    = ready_q;
   assign cur_buf_o  = cur_q;
   assign busy_o     = busy_q;
   assign timeout_o  = timeout_q;
   assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_lab_digitize_sched.sv
// Directed bench for lab_digitize_sched (short TIMEOUT and narrow drop counter for reachable edges).
module tb_lab_digitize_sched;

   localparam int unsigned NBUF    = 4;
   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned CNTW    = 4;

   logic            clk = 1'b0;
   logic            nrst;
   logic            enable;
   logic [NBUF-1:0] hold;
   logic            done;
   logic [NBUF-1:0] clear;
   logic [NBUF-1:0] digitize;
   logic [NBUF-1:0] ready;
   logic [1:0]      cur_buf;
   logic            busy;
   logic            timeout;
   logic [CNTW-1:0] drop_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   lab_digitize_sched #(.NBUF(NBUF), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
      .clk_i      (clk),
      .nrst_i     (nrst),
      .enable_i   (enable),
      .hold_i     (hold),
      .done_i     (done),
      .clear_i    (clear),
      .digitize_o (digitize),
      .ready_o    (ready),
      .cur_buf_o  (cur_buf),
      .busy_o     (busy),
      .timeout_o  (timeout),
      .drop_cnt_o (drop_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      nrst = 1'b0; enable = 1'b1; hold = '0; done = 1'b0; clear = '0;
      tick(); tick();
      nrst = 1'b1;
      tick();
   endtask

   // Edge on the masked buffers; returns one cycle after the buffers become PENDING.
   task automatic hold_pulse(input logic [NBUF-1:0] m);
      hold = m; tick();
      hold = '0; tick();
   endtask

   task automatic test_reset();
      nrst = 1'b0; enable = 1'b1; hold = '0; done = 1'b0; clear = '0;
      #1;
      tests++;
      if ({digitize, ready, cur_buf, busy, timeout, drop_cnt} !== '0) begin
         fails++; $display("FAIL reset_outputs: got %h expected 0", {digitize, ready, cur_buf, busy, timeout, drop_cnt});
      end
      tick(); nrst = 1'b1; tick();
      tests++;
      if ({digitize, ready, busy, drop_cnt} !== '0) begin
         fails++; $display("FAIL reset_idle: got %h expected 0", {digitize, ready, busy, drop_cnt});
      end
   endtask

   task automatic test_single();
      do_reset();
      hold = 4'b0100; tick();
      tests++;
      if (digitize !== 4'b0000) begin fails++; $display("FAIL single_early: got %b expected 0000", digitize); end
      hold = '0; tick();
      tests++;
      if (digitize !== 4'b0100) begin fails++; $display("FAIL single_dig: got %b expected 0100", digitize); end
      tests++;
      if (cur_buf !== 2'd2) begin fails++; $display("FAIL single_cur: got %0d expected 2", cur_buf); end
      done = 1'b1; tick(); done = 1'b0;
      tests++;
      if (digitize !== 4'b0000) begin fails++; $display("FAIL single_dig_off: got %b expected 0000", digitize); end
      tests++;
      if (ready !== 4'b0100) begin fails++; $display("FAIL single_ready: got %b expected 0100", ready); end
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL single_busy: got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      hold = 4'hF; tick(); hold = '0; tick();
      for (int b = 0; b < 4; b++) begin
         tests++;
         if (digitize !== 4'(1 << b)) begin fails++; $display("FAIL b2b_dig%0d: got %b expected %b", b, digitize, 4'(1 << b)); end
         tests++;
         if (cur_buf !== 2'(b)) begin fails++; $display("FAIL b2b_cur%0d: got %0d expected %0d", b, cur_buf, b); end
         done = 1'b1; tick(); done = 1'b0;
         tests++;
         if (digitize !== 4'b0000) begin fails++; $display("FAIL b2b_gap%0d: got %b expected 0000", b, digitize); end
         if (b < 3) tick();
      end
      tests++;
      if (ready !== 4'hF) begin fails++; $display("FAIL b2b_ready: got %b expected 1111", ready); end
      tests++;
      if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy: got %b expected 1", busy); end
      clear = 4'b0010; tick(); clear = '0;
      tests++;
      if (ready !== 4'b1101) begin fails++; $display("FAIL b2b_clear_ready: got %b expected 1101", ready); end
      tick();
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_clr: got %b expected 0", busy); end
   endtask

   task automatic test_drop();
      do_reset();
      hold_pulse(4'b0010);
      done = 1'b1; tick(); done = 1'b0;
      for (int k = 0; k < 3; k++) hold_pulse(4'b0010);
      tests++;
      if (drop_cnt !== 4'd3) begin fails++; $display("FAIL drop_cnt3: got %0d expected 3", drop_cnt); end
      tests++;
      if (ready !== 4'b0010) begin fails++; $display("FAIL drop_ready: got %b expected 0010", ready); end
      clear = 4'b0010; hold = 4'b0010; tick(); clear = '0; hold = '0;
      tests++;
      if (ready !== 4'b0000 || drop_cnt !== 4'd3) begin
         fails++; $display("FAIL clr_edge: got ready=%b drop=%0d expected ready=0000 drop=3", ready, drop_cnt);
      end
      tick();
      tests++;
      if (digitize !== 4'b0010) begin fails++; $display("FAIL clr_edge_dig: got %b expected 0010", digitize); end
      done = 1'b1; tick(); done = 1'b0;
      for (int k = 0; k < 12; k++) hold_pulse(4'b0010);
      tests++;
      if (drop_cnt !== 4'd15) begin fails++; $display("FAIL drop_cnt15: got %0d expected 15", drop_cnt); end
      for (int k = 0; k < 2; k++) hold_pulse(4'b0010);
      tests++;
      if (drop_cnt !== 4'd15) begin fails++; $display("FAIL drop_sat: got %0d expected 15", drop_cnt); end
   endtask

   task automatic test_timeout();
      do_reset();
      hold_pulse(4'b0001);
      for (int k = 0; k < 15; k++) tick();
      tests++;
      if (digitize !== 4'b0001 || timeout !== 1'b0) begin
         fails++; $display("FAIL to_wait16: got dig=%b to=%b expected dig=0001 to=0", digitize, timeout);
      end
      tick();
      tests++;
      if (digitize !== 4'b0000 || timeout !== 1'b1 || ready !== 4'b0000) begin
         fails++; $display("FAIL to_fire: got dig=%b to=%b rdy=%b expected 0000/1/0000", digitize, timeout, ready);
      end
      tick();
      tests++;
      if (timeout !== 1'b0) begin fails++; $display("FAIL to_pulse: got %b expected 0", timeout); end
      hold_pulse(4'b0001);
      tests++;
      if (digitize !== 4'b0001) begin fails++; $display("FAIL to_refree: got %b expected 0001", digitize); end
      for (int k = 0; k < 15; k++) tick();
      done = 1'b1; tick(); done = 1'b0;
      tests++;
      if (ready !== 4'b0001 || timeout !== 1'b0 || digitize !== 4'b0000) begin
         fails++; $display("FAIL to_done_wins: got rdy=%b to=%b dig=%b expected 0001/0/0000", ready, timeout, digitize);
      end
   endtask

   task automatic test_enable();
      do_reset();
      hold_pulse(4'b0010);
      done = 1'b1; tick(); done = 1'b0;
      clear = 4'b0010; tick(); clear = '0;
      enable = 1'b0;
      hold = 4'b1001; tick(); hold = '0; tick(); tick();
      tests++;
      if (digitize !== 4'b0000) begin fails++; $display("FAIL en_off: got %b expected 0000", digitize); end
      enable = 1'b1; tick();
      tests++;
      if (digitize !== 4'b1000 || cur_buf !== 2'd3) begin
         fails++; $display("FAIL en_first: got dig=%b cur=%0d expected 1000/3", digitize, cur_buf);
      end
      done = 1'b1; tick(); done = 1'b0; tick();
      tests++;
      if (digitize !== 4'b0001 || cur_buf !== 2'd0) begin
         fails++; $display("FAIL en_second: got dig=%b cur=%0d expected 0001/0", digitize, cur_buf);
      end
      done = 1'b1; tick(); done = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      hold_pulse(4'b0001);
      done = 1'b1; tick(); done = 1'b0;
      hold_pulse(4'b0100);
      tests++;
      if (digitize !== 4'b0100 || ready !== 4'b0001) begin
         fails++; $display("FAIL rst_pre: got dig=%b rdy=%b expected 0100/0001", digitize, ready);
      end
      #2 nrst = 1'b0;
      #1;
      tests++;
      if (digitize !== 4'b0000 || ready !== 4'b0000) begin
         fails++; $display("FAIL rst_async: got dig=%b rdy=%b expected 0000/0000", digitize, ready);
      end
      #1 nrst = 1'b1;
      done = 1'b1; tick(); done = 1'b0; tick();
      tests++;
      if (digitize !== 4'b0000 || ready !== 4'b0000 || busy !== 1'b0) begin
         fails++; $display("FAIL rst_late_done: got dig=%b rdy=%b busy=%b expected 0000/0000/0", digitize, ready, busy);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_drop();
      test_timeout();
      test_enable();
      test_reset_mid_wait();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
